player_plot_sequencer: RTL and testbench
========================================

Name: player_plot_sequencer

Overview:
- Parametrised successor to the fixed 4-player draw controller/datapath pair: scans N player positions round-robin and drives one pixel write per cycle into vga_adapter.
- Plots a player only when its position changed since the last plot, or a refresh is forced.
- Adds a per-player enable mask, a full-screen clear sweep and a plot_ready stall handshake.
- Sits between the position/move logic and vga_adapter (x, y, colour, plot).

Parameters:
- NUM_PLAYERS, 4, number of player channels (1..16).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOR_W, 3, colour width.
- SCREEN_W, 160, visible width in pixels; x range 0..SCREEN_W-1.
- SCREEN_H, 120, visible height in pixels; y range 0..SCREEN_H-1.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pos  in  NUM_PLAYERS*(X_W+Y_W)  packed positions; player k at [k*P +: P], P=X_W+Y_W, x in the upper X_W bits.
- player_colour  in  NUM_PLAYERS*COLOR_W  packed colours; player k at [k*COLOR_W +: COLOR_W].
- enable  in  NUM_PLAYERS  per-player plot enable.
- clear_req  in  1  request a full-screen clear (level or pulse).
- bg_colour  in  COLOR_W  colour used by the clear sweep.
- plot_ready  in  1  sink accepts the current pixel at this edge; tie to 1 for vga_adapter.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  COLOR_W  pixel colour.
- plot  out  1  pixel valid.
- clear_busy  out  1  high while the clear sweep is running.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (async, resetn=0):
  - x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0.
  - State SCAN, idx=0.
  - last_pos[k]=0 and force[k]=1 for every k.
  - clear_pend=0.
- Outputs are registered; nothing is combinational from inputs to outputs.
- Stall rule:
  - If plot=1 and plot_ready=0 at an edge, x/y/colour/plot hold.
  - idx, FSM state and clear counters hold.
  - No player is examined that cycle.
  - Otherwise the current pixel counts as accepted and the block advances.
- SCAN, one player per non-stalled cycle, player idx:
  - dirty = enable[idx] && (pos_k != last_pos[idx] || force[idx]) && x_k < SCREEN_W && y_k < SCREEN_H.
  - If dirty: next cycle plot=1, x=x_k, y=y_k, colour=player_colour_k; last_pos[idx] <= pos_k; force[idx] <= 0.
  - If not dirty: next cycle plot=0.
  - Out-of-range positions are never plotted and never recorded; force stays set.
  - idx increments and wraps NUM_PLAYERS-1 -> 0.
  - Latency: position change to plot is at most NUM_PLAYERS cycles when plot_ready=1.
- Clear entry:
  - clear_req=1 in SCAN sets clear_pend.
  - At the next non-stalled edge with clear_pend=1: enter CLEAR, cx=0, cy=0, clear_busy=1, clear_pend=0.
  - Clear entry takes priority over a dirty player at the same edge; that player stays unrecorded.
- CLEAR:
  - Each non-stalled cycle emits plot=1, x=cx, y=cy, colour=bg_colour.
  - cx increments and wraps at SCREEN_W-1; cy increments on cx wrap.
  - After pixel (SCREEN_W-1, SCREEN_H-1) is accepted: return to SCAN, clear_busy=0, clear_done=1 for one cycle, all force bits set, idx=0.
  - The sweep issues exactly SCREEN_W*SCREEN_H plots; 19200 with the default parameters.
  - clear_req is ignored while clear_busy=1; it is not queued.
- enable[k] falling mid-operation: player k is skipped from the next examination; a pixel already issued completes normally.
- NUM_PLAYERS=1: idx stays 0 and the player is examined every cycle.

Test Plan:
- Reset, 4 players at (10,10),(20,20),(30,30),(40,40), enable=4'hF, plot_ready=1:
  - Exactly 4 plots, in order p0..p3, with their player colours.
  - Then plot=0 while positions are static.
- Move p2 to (31,30) only: exactly one plot, x=31 y=30 colour=player_colour_2, within 4 cycles.
- Hold plot_ready=0 for 5 cycles during a pending plot: x/y/colour/plot stay constant; the next plot appears only after plot_ready returns to 1.
- Pulse clear_req with bg_colour=3'b000:
  - clear_busy high for 19200 accepted cycles; first pixel (0,0), last pixel (159,119).
  - clear_done pulses once; all 4 enabled players are then replotted.
- enable=4'b0101 with all positions changed: only p0 and p2 plotted. Set p1 to x=200: never plotted even once p1 is enabled.
- Assert resetn=0 mid-clear at pixel (50,60):
  - plot, clear_busy and clear_done drop immediately.
  - After release the block scans and replots all enabled players.

Source files
------------

// File: rtl/player_plot_sequencer.sv
// player_plot_sequencer: scans N player positions round-robin and issues at most
// one pixel write per cycle towards vga_adapter. A player is drawn only when its
// position moved since its last plot or a refresh is forced. A clear request runs
// a full-screen raster sweep in the background colour.
//
// Handshake: plot is the valid for {x, y, colour}. A pixel is accepted at a rising
// edge where plot=1 and plot_ready=1. While plot=1 and plot_ready=0 the pixel and
// all sequencing state hold. When plot=0 the block always advances.
module player_plot_sequencer #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic                               CLOCK_50,
  input  logic                               resetn,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]   pos,
  input  logic [NUM_PLAYERS*COLOR_W-1:0]     player_colour,
  input  logic [NUM_PLAYERS-1:0]             enable,
  input  logic                               clear_req,
  input  logic [COLOR_W-1:0]                 bg_colour,
  input  logic                               plot_ready,
  output logic [X_W-1:0]                     x,
  output logic [Y_W-1:0]                     y,
  output logic [COLOR_W-1:0]                 colour,
  output logic                               plot,
  output logic                               clear_busy,
  output logic                               clear_done,
  output logic [1:0]                         dbg_state
);

  localparam int P     = X_W + Y_W;
  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned SW_U = SCREEN_W;
  localparam int unsigned SH_U = SCREEN_H;
  localparam logic [X_W-1:0]   X_LAST   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(SCREEN_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PLAYERS - 1);

  // ST_CLEAR_LAST means the final sweep pixel is on the outputs awaiting acceptance.
  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_CLEAR      = 2'd1,
    ST_CLEAR_LAST = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [P-1:0]           last_pos_q [NUM_PLAYERS];
  logic [P-1:0]           last_pos_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] force_bits_q, force_bits_d;
  logic                   clear_pend_q, clear_pend_d;
  logic [X_W-1:0]         cx_q, cx_d;
  logic [Y_W-1:0]         cy_q, cy_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [COLOR_W-1:0]     colour_q, colour_d;
  logic                   plot_q, plot_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [P-1:0]           cur_pos, cur_last;
  logic [X_W-1:0]         cur_x;
  logic [Y_W-1:0]         cur_y;
  logic [COLOR_W-1:0]     cur_colour;
  logic                   cur_en, cur_force, in_range, dirty, stall;

  // Select the fields of the player currently under examination.
  always_comb begin
    cur_pos    = '0;
    cur_last   = '0;
    cur_colour = '0;
    cur_en     = 1'b0;
    cur_force  = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_pos    = pos[k*P +: P];
        cur_last   = last_pos_q[k];
        cur_colour = player_colour[k*COLOR_W +: COLOR_W];
        cur_en     = enable[k];
        cur_force  = force_bits_q[k];
      end
    end
    cur_x    = cur_pos[P-1 -: X_W];
    cur_y    = cur_pos[Y_W-1:0];
    in_range = (32'(cur_x) < SW_U) && (32'(cur_y) < SH_U);
    dirty    = cur_en && ((cur_pos != cur_last) || cur_force) && in_range;
    stall    = plot_q && !plot_ready;
  end

  // Next-state logic: scan step, clear entry, sweep and sweep completion.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    force_bits_d = force_bits_q;
    clear_pend_d = clear_pend_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = plot_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) last_pos_d[k] = last_pos_q[k];

    // A request seen during scanning is latched even across a stall.
    if (state_q == ST_SCAN && clear_req) clear_pend_d = 1'b1;

    if (!stall) begin
      case (state_q)
        ST_SCAN: begin
          if (clear_pend_q) begin
            state_d      = ST_CLEAR;
            cx_d         = '0;
            cy_d         = '0;
            busy_d       = 1'b1;
            clear_pend_d = 1'b0;
            plot_d       = 1'b0;
          end else begin
            plot_d = dirty;
            if (dirty) begin
              x_d      = cur_x;
              y_d      = cur_y;
              colour_d = cur_colour;
              for (int k = 0; k < NUM_PLAYERS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                  last_pos_d[k]   = cur_pos;
                  force_bits_d[k] = 1'b0;
                end
              end
            end
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
        end
        ST_CLEAR: begin
          plot_d   = 1'b1;
          x_d      = cx_q;
          y_d      = cy_q;
          colour_d = bg_colour;
          if (cx_q == X_LAST) begin
            cx_d = '0;
            if (cy_q == Y_LAST) state_d = ST_CLEAR_LAST;
            else                cy_d    = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
        ST_CLEAR_LAST: begin
          state_d      = ST_SCAN;
          plot_d       = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          force_bits_d = '1;
          idx_d        = '0;
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_SCAN;
      idx_q        <= '0;
      force_bits_q <= '1;
      clear_pend_q <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int k = 0; k < NUM_PLAYERS; k++) last_pos_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      force_bits_q <= force_bits_d;
      clear_pend_q <= clear_pend_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int k = 0; k < NUM_PLAYERS; k++) last_pos_q[k] <= last_pos_d[k];
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_player_plot_sequencer.sv
// Bench for player_plot_sequencer with the default 4-player, 160x120 geometry.
module tb_player_plot_sequencer;

  localparam int N   = 4;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int P   = X_W + Y_W;
  localparam int W   = X_W + Y_W + C_W;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N*P-1:0]   pos = '0;
  logic [N*C_W-1:0] player_colour;
  logic [N-1:0]     enable = '1;
  logic             clear_req = 1'b0;
  logic [C_W-1:0]   bg_colour = '0;
  logic             plot_ready = 1'b1;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [C_W-1:0]   colour;
  logic             plot, clear_busy, clear_done;
  logic [1:0]       dbg_state;

  player_plot_sequencer dut (
    .CLOCK_50(clk), .resetn(resetn), .pos(pos), .player_colour(player_colour),
    .enable(enable), .clear_req(clear_req), .bg_colour(bg_colour),
    .plot_ready(plot_ready), .x(x), .y(y), .colour(colour), .plot(plot),
    .clear_busy(clear_busy), .clear_done(clear_done), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0]   exp_q[$];
  bit             strict = 1'b0;
  logic [C_W-1:0] col [N];
  logic [X_W-1:0] px [N];
  logic [Y_W-1:0] py [N];

  // clear sweep model, owned by the monitor
  logic [X_W-1:0] cx_m = '0;
  logic [Y_W-1:0] cy_m = '0;
  int             clr_cnt = 0;
  int             done_cnt = 0;
  logic           busy_prev = 1'b0;
  logic [P-1:0]   first_px = '0;
  logic [P-1:0]   last_px = '0;

  typedef struct packed {
    logic [N-1:0]         chg;
    logic [N-1:0][X_W-1:0] xs;
    logic [N-1:0][Y_W-1:0] ys;
    logic [N-1:0]         en;
    logic [N-1:0]         exp_mask;
  } scene_t;

  // ---------------- driver tasks ----------------
  task automatic set_pos(input int k, input int xv, input int yv);
    px[k] = X_W'(xv);
    py[k] = Y_W'(yv);
    pos[k*P +: P] = {px[k], py[k]};
  endtask

  task automatic push_player(input int k);
    exp_q.push_back({px[k], py[k], col[k]});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected plots missing after %0d cycles, want 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  function automatic scene_t mk(input logic [N-1:0] chg, input logic [N-1:0] en,
                                input logic [N-1:0] m, input int x0, input int y0,
                                input int x1, input int y1, input int x2, input int y2,
                                input int x3, input int y3);
    scene_t s;
    s.chg = chg; s.en = en; s.exp_mask = m;
    s.xs[0] = X_W'(x0); s.ys[0] = Y_W'(y0);
    s.xs[1] = X_W'(x1); s.ys[1] = Y_W'(y1);
    s.xs[2] = X_W'(x2); s.ys[2] = Y_W'(y2);
    s.xs[3] = X_W'(x3); s.ys[3] = Y_W'(y3);
    return s;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    int hit;
    if (clear_busy && !busy_prev) begin
      cx_m = '0;
      cy_m = '0;
      clr_cnt = 0;
    end
    busy_prev = clear_busy;
    if (clear_done) done_cnt++;
    if (plot && plot_ready) begin
      checks++;
      if (clear_busy) begin
        if ({x, y, colour} !== {cx_m, cy_m, bg_colour}) begin
          errors++;
          $display("FAIL clear_pixel: got x=%0d y=%0d c=%0d, want x=%0d y=%0d c=%0d",
                   x, y, colour, cx_m, cy_m, bg_colour);
        end
        if (clr_cnt == 0) first_px = {x, y};
        last_px = {x, y};
        clr_cnt++;
        if (cx_m == X_W'(159)) begin
          cx_m = '0;
          cy_m = cy_m + 1'b1;
        end else begin
          cx_m = cx_m + 1'b1;
        end
      end else begin
        hit = -1;
        if (strict) begin
          if (exp_q.size() > 0 && exp_q[0] == {x, y, colour}) hit = 0;
        end else begin
          foreach (exp_q[i]) if (hit < 0 && exp_q[i] == {x, y, colour}) hit = i;
        end
        if (hit >= 0) begin
          exp_q.delete(hit);
        end else begin
          errors++;
          $display("FAIL player_plot: got x=%0d y=%0d c=%0d, want %0s (queued=%0d, front=%0h)",
                   x, y, colour, (exp_q.size() != 0) ? "a queued pixel" : "no plot",
                   exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : '0);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  scene_t scenes [5];
  logic [W-1:0] snap;
  int n;
  int done_before;

  initial begin
    col[0] = 3'd5; col[1] = 3'd2; col[2] = 3'd3; col[3] = 3'd4;
    player_colour = {col[3], col[2], col[1], col[0]};
    set_pos(0, 10, 10); set_pos(1, 20, 20); set_pos(2, 30, 30); set_pos(3, 40, 40);

    scenes[0] = mk(4'b0100, 4'hF, 4'b0100,   0,   0,   0, 0, 31,  30,   0,   0);
    scenes[1] = mk(4'b1001, 4'hF, 4'b1001,   0,   0,   0, 0,  0,   0, 159, 119);
    scenes[2] = mk(4'b1010, 4'hF, 4'b0000,   0,   0, 160, 5,  0,   0,  12, 120);
    scenes[3] = mk(4'b1010, 4'hF, 4'b0010,   0,   0, 100, 50, 0,   0, 159, 119);
    scenes[4] = mk(4'b0000, 4'hF, 4'b0000,   0,   0,   0, 0,  0,   0,   0,   0);

    // reset values
    tick(3);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_clear_busy", 32'(clear_busy), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // first scan after reset plots every player in index order
    strict = 1'b1;
    for (int k = 0; k < N; k++) push_player(k);
    @(posedge clk); #1;
    resetn = 1'b1;
    drain("reset_scan", N + 2);
    strict = 1'b0;
    tick(8);
    chk("static_no_plot", 32'(plot), 0);

    // table-driven position scenes
    for (int i = 0; i < 5; i++) begin
      enable = scenes[i].en;
      for (int k = 0; k < N; k++)
        if (scenes[i].chg[k]) set_pos(k, int'(scenes[i].xs[k]), int'(scenes[i].ys[k]));
      for (int k = 0; k < N; k++)
        if (scenes[i].exp_mask[k]) push_player(k);
      drain($sformatf("scene%0d", i), N + 1);
      tick(8);
      chk($sformatf("scene%0d_quiet", i), 32'(plot), 0);
    end

    // stall: a held pixel must not change or be replaced until plot_ready returns
    set_pos(1, 101, 50);
    set_pos(3, 158, 119);
    push_player(1);
    push_player(3);
    n = 0;
    while (!plot && n < 8) begin tick(1); n++; end
    chk("stall_plot_seen", 32'(plot), 1);
    snap = {x, y, colour};
    plot_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk($sformatf("stall_hold%0d", c), {13'd0, plot, x, y, colour}, {13'd0, 1'b1, snap});
    end
    chk("stall_queue", 32'(exp_q.size()), 2);
    plot_ready = 1'b1;
    drain("stall_release", N + 3);
    tick(6);

    // full clear sweep, then all enabled players are redrawn
    bg_colour = 3'b000;
    done_before = done_cnt;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    for (int k = 0; k < N; k++) push_player(k);
    n = 0;
    while (!clear_done && n < 19400) begin tick(1); n++; end
    chk("clear_done_seen", 32'(clear_done), 1);
    chk("clear_pixel_count", 32'(clr_cnt), 19200);
    chk("clear_first_px", 32'(first_px), 32'({8'd0, 7'd0}));
    chk("clear_last_px", 32'(last_px), 32'({8'd159, 7'd119}));
    drain("clear_replot", N + 2);
    tick(6);
    chk("clear_done_once", 32'(done_cnt - done_before), 1);
    chk("clear_busy_low", 32'(clear_busy), 0);

    // enable mask: only p0 and p2 may draw
    enable = 4'b0101;
    set_pos(0, 5, 6); set_pos(1, 7, 8); set_pos(2, 9, 10); set_pos(3, 11, 12);
    push_player(0);
    push_player(2);
    drain("enable_mask", N + 1);
    tick(8);
    // p1 off-screen stays undrawn; p3 moved while disabled so it now draws
    set_pos(1, 200, 8);
    enable = 4'hF;
    push_player(3);
    drain("enable_restore", N + 1);
    tick(12);
    chk("offscreen_quiet", 32'(plot), 0);

    // reset in the middle of a sweep
    bg_colour = 3'b111;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    n = 0;
    while (!(clear_busy && plot && x == 8'd50 && y == 7'd60) && n < 12000) begin tick(1); n++; end
    chk("midclear_reached", 32'(clear_busy && plot && x == 8'd50 && y == 7'd60), 1);
    resetn = 1'b0;
    #1;
    chk("midclear_rst_plot", 32'(plot), 0);
    chk("midclear_rst_busy", 32'(clear_busy), 0);
    chk("midclear_rst_done", 32'(clear_done), 0);
    exp_q.delete();
    tick(2);
    resetn = 1'b1;
    push_player(0);
    push_player(2);
    push_player(3);
    drain("post_reset_replot", N + 2);
    tick(10);
    chk("post_reset_quiet", 32'(plot), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
